// File: rtl/polar_enc_pkg.sv
// Shared types and helper functions for the polar/CRC encoder and decoder.
// The helpers work on fixed maximum-width vectors so that every instance,
// whatever its N or CRC_W, can call the same functions.
package polar_enc_pkg;

    // Largest supported code length and CRC width.
    localparam int MAX_N     = 1024;
    localparam int MAX_CRC_W = 32;

    // Encoder control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFORM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // One bit of a non-reflected, MSB-first CRC register of width w.
    // Bits above w are forced to zero so narrower CRCs stay clean.
    function automatic logic [MAX_CRC_W-1:0] crc_step(
        input logic [MAX_CRC_W-1:0] crc,
        input logic                 din,
        input logic [MAX_CRC_W-1:0] poly,
        input int                   w
    );
        logic                 fb;
        logic [MAX_CRC_W-1:0] mask;
        logic [MAX_CRC_W-1:0] r;
        fb   = din ^ crc[w-1];
        mask = (MAX_CRC_W'(1) << w) - MAX_CRC_W'(1);
        r    = crc << 1;
        if (fb) begin
            r = r ^ poly;
        end
        return r & mask;
    endfunction

    // One butterfly stage s of the polar transform: every position whose
    // bit s is clear absorbs its partner 2^s above it. Partner pairs never
    // overlap, so the whole stage is evaluated against the input vector.
    // Positions at or above the real code length are zero and stay zero,
    // so they never disturb the low N bits.
    function automatic logic [MAX_N-1:0] polar_stage(
        input logic [MAX_N-1:0] x,
        input int               s
    );
        logic [MAX_N-1:0] r;
        r = x;
        for (int i = 0; i < MAX_N; i++) begin
            if (((i >> s) & 1) == 0) begin
                r[i] = x[i] ^ x[i + (1 << s)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/polar_crc_calc.sv
// Combinational CRC over a K-bit word, MSB first, no reflection and no
// final XOR. Shared between the polar encoder and decoder.
module polar_crc_calc
    import polar_enc_pkg::*;
#(
    parameter int                K        = 24,
    parameter int                CRC_W    = 16,
    parameter logic [CRC_W-1:0]  CRC_POLY = 16'h1021,
    parameter logic [CRC_W-1:0]  CRC_INIT = 16'h0000
) (
    input  logic [K-1:0]     data,
    output logic [CRC_W-1:0] crc
);

    logic [MAX_CRC_W-1:0] crc_reg;
    logic                 crc_unused;

    // Shift every payload bit through the CRC register, MSB first.
    always_comb begin
        crc_reg = MAX_CRC_W'(CRC_INIT);
        for (int i = K - 1; i >= 0; i--) begin
            crc_reg = crc_step(crc_reg, data[i], MAX_CRC_W'(CRC_POLY), CRC_W);
        end
    end

    assign crc        = crc_reg[CRC_W-1:0];
    assign crc_unused = ^crc_reg;

endmodule

// File: rtl/polar_crc_encoder_stream.sv
// Stream-handshaked polar encoder: takes a K-bit payload, appends an
// optional CRC, places the info bits at the top of u with frozen zeros
// below, runs the polar transform a few butterfly stages per clock and
// holds the codeword until the consumer takes it.
module polar_crc_encoder_stream
    import polar_enc_pkg::*;
#(
    parameter int                N            = 64,
    parameter int                K            = 24,
    parameter int                CRC_EN       = 1,
    parameter int                CRC_W        = 16,
    parameter logic [CRC_W-1:0]  CRC_POLY     = 16'h1021,
    parameter logic [CRC_W-1:0]  CRC_INIT     = 16'h0000,
    parameter int                BF_PER_CYCLE = 1,
    parameter int                CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     codeword,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int LOG_N  = $clog2(N);
    localparam int INFO_W = K + ((CRC_EN != 0) ? CRC_W : 0);

    state_t             state;
    logic [4:0]         stage;
    logic [N-1:0]       x;
    logic [N-1:0]       x_next;
    logic [N-1:0]       u_load;
    logic [INFO_W-1:0]  info;
    logic [MAX_N-1:0]   x_wide;
    logic               last_step;
    logic               x_wide_unused;

    // Info bits: payload on top, CRC of the payload right below it.
    generate
        if (CRC_EN != 0) begin : g_crc
            logic [CRC_W-1:0] crc;
            polar_crc_calc #(
                .K        (K),
                .CRC_W    (CRC_W),
                .CRC_POLY (CRC_POLY),
                .CRC_INIT (CRC_INIT)
            ) u_crc (
                .data (data_in),
                .crc  (crc)
            );
            assign info = {data_in, crc};
        end else begin : g_nocrc
            assign info = data_in;
        end
    endgenerate

    // Left-align the info bits so the frozen zeros fill the low positions.
    assign u_load = N'(info) << (N - INFO_W);

    assign in_ready = (state == IDLE) && !rst;

    // Apply this cycle's group of butterfly stages and flag the final group.
    always_comb begin
        x_wide = MAX_N'(x);
        for (int j = 0; j < BF_PER_CYCLE; j++) begin
            if (int'(stage) + j < LOG_N) begin
                x_wide = polar_stage(x_wide, int'(stage) + j);
            end
        end
        x_next    = x_wide[N-1:0];
        last_step = (int'(stage) + BF_PER_CYCLE >= LOG_N);
    end

    assign x_wide_unused = ^x_wide;

    // Control FSM with the working vector, codeword register and frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            x         <= '0;
            codeword  <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= u_load;
                        stage <= '0;
                        state <= XFORM;
                    end
                end
                XFORM: begin
                    x <= x_next;
                    if (last_step) begin
                        codeword  <= x_next;
                        out_valid <= 1'b1;
                        stage     <= '0;
                        state     <= HOLD;
                    end else begin
                        stage <= stage + 5'(BF_PER_CYCLE);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
